mini_cpu_datapath: RTL and testbench
====================================

Name: mini_cpu_datapath

Overview:
Execution datapath of the mini CPU: a 16-entry x 16-bit register file plus an 8-operation ALU.
- The top-level FSM presents opcode, register addresses and a sign-magnitude immediate.
- The operation commits on the release of the "enviar" button (0->1 edge, sampled on clk).
- Outputs carry the committed result and the two read operands for the LCD driver.

Parameters:
DATA_W, 16, register and result width in bits
IMM_W, 7, immediate width: bit IMM_W-1 is sign, remaining bits are magnitude

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
opcode  input  3  operation code
addr1  input  4  destination register; source for DISPLAY
addr2  input  4  source A register
addr3  input  4  source B register
imm  input  7  sign-magnitude immediate: imm[6]=sign, imm[5:0]=magnitude
enviar  input  1  commit button level, synchronous to clk; commit on 0->1 edge
v1  output  16  combinational R[addr2]
v2  output  16  combinational R[addr3]
result  output  16  registered value of last committed operation
done  output  1  one-cycle pulse after each commit
ovf  output  1  registered signed-overflow flag (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - all 16 registers = 0; result = 0, done = 0, ovf = 0.
  - Internal enviar_q = 1, so a button already high at reset release does not commit.
- Edge detect: enviar_q <= enviar each clk. Commit when enviar=1 and enviar_q=0.
- Commit timing:
  - On a commit edge, register write, result update and done=1 all happen on that same edge.
  - done returns to 0 on the next edge.
  - Without a commit: registers, result and ovf hold; done=0.
- Immediate: immx = sign ? -mag : +mag, sign-extended to 16 bits. Range -63..+63; sign=1 with mag=0 yields 0.
- Operations (A=R[addr2], B=R[addr3], 16-bit two's-complement, results wrap modulo 2^16):
  - 000 LOAD: R[addr1] <= immx; result <= immx
  - 001 ADD: R[addr1] <= A+B
  - 010 ADDI: R[addr1] <= A+immx
  - 011 SUB: R[addr1] <= A-B
  - 100 SUBI: R[addr1] <= A-immx
  - 101 MUL: R[addr1] <= low 16 bits of signed A*B
  - 110 CLEAR: all registers <= 0; result <= 0
  - 111 DISPLAY: no register write; result <= R[addr1]
  - For 001..101, result <= the value written.
- Read/write ordering:
  - Operands are read before the write on the same edge. For example, ADD with addr1=addr2 uses the old A.
  - v1/v2 show new contents from the cycle after the commit.
- No reserved opcodes. Register 0 is general purpose.
- enviar held high: single commit only. A new commit requires enviar to return to 0 first.
- rst asserted mid-operation: immediate clear per reset values. A pending edge is discarded.

Optional Feature:
- Macro DATAPATH_OVF_EN defined:
  - ovf is set on a commit for ADD/ADDI/SUB/SUBI when the signed 16-bit result overflows.
  - For MUL, ovf is set when the full 32-bit signed product is outside -32768..32767.
  - LOAD/CLEAR/DISPLAY commits clear ovf.
  - ovf holds between commits.
- Macro not defined: ovf is constant 0; no overflow logic is synthesized.

Test Plan:
- Reset then LOAD addr1=3, imm=7'b0000101, enviar 0->1 -> next edge R3=5, result=5, done high exactly one cycle; v1=5 with addr2=3.
- LOAD R1=+20, LOAD R2=imm 7'b1000111 (-7), ADD addr1=4 addr2=1 addr3=2 -> result=13; SUB same -> result=27 (0x001B).
- SUBI R5 = R1 - (-63), then MUL R6=R5*R5 -> R5=83, R6=6889 (0x1AE9); imm 7'b1000000 LOAD -> 0.
- Overflow: R7=0x7FFF via repeated ADDI, ADDI +1 -> result=0x8000, ovf=1 (DATAPATH_OVF_EN) or 0 (without); DISPLAY clears ovf.
- enviar held high 10 cycles after a single rising edge -> exactly one commit/done; enviar high at rst release -> no commit.
- CLEAR after loading R0..R15 -> all v1/v2 reads 0, result=0; async rst pulse mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/mini_cpu_datapath_if.sv
// Operand/command bus between the mini CPU control FSM (master) and the
// execution datapath (slave).
interface mini_cpu_datapath_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IMM_W  = 7
);
    logic [2:0]        opcode;
    logic [3:0]        addr1;
    logic [3:0]        addr2;
    logic [3:0]        addr3;
    logic [IMM_W-1:0]  imm;
    logic              enviar;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [DATA_W-1:0] result;
    logic              done;
    logic              ovf;

    modport master (
        output opcode, addr1, addr2, addr3, imm, enviar,
        input  v1, v2, result, done, ovf
    );

    modport slave (
        input  opcode, addr1, addr2, addr3, imm, enviar,
        output v1, v2, result, done, ovf
    );
endinterface

// File: rtl/mini_cpu_datapath.sv
// Mini CPU execution datapath: 16 x DATA_W register file and 8-op ALU, committed on
// the rising edge of enviar. Optional signed-overflow flag under DATAPATH_OVF_EN.
module mini_cpu_datapath #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IMM_W  = 7
) (
    input logic                 clk,
    input logic                 rst,
    mini_cpu_datapath_if.slave  bus
);
    typedef enum logic [2:0] {
        OpLoad    = 3'b000,
        OpAdd     = 3'b001,
        OpAddi    = 3'b010,
        OpSub     = 3'b011,
        OpSubi    = 3'b100,
        OpMul     = 3'b101,
        OpClear   = 3'b110,
        OpDisplay = 3'b111
    } op_e;

    logic [DATA_W-1:0] regs_q [16];
    logic [DATA_W-1:0] result_q;
    logic              done_q;
    logic              enviar_q;

    logic [DATA_W-1:0] op_a, op_b, mag_ext, immx;
    logic [DATA_W-1:0] sum_ab, sum_ai, dif_ab, dif_ai, mul_lo;
    logic [DATA_W-1:0] res_val;
    logic              wr_en, clr_all, commit;
    op_e               op;

    assign op      = op_e'(bus.opcode);
    assign op_a    = regs_q[bus.addr2];
    assign op_b    = regs_q[bus.addr3];
    assign commit  = bus.enviar & ~enviar_q;
    assign mag_ext = {{(DATA_W-IMM_W+1){1'b0}}, bus.imm[IMM_W-2:0]};
    assign immx    = bus.imm[IMM_W-1] ? -mag_ext : mag_ext;
    assign sum_ab  = op_a + op_b;
    assign sum_ai  = op_a + immx;
    assign dif_ab  = op_a - op_b;
    assign dif_ai  = op_a - immx;

    always_comb begin
        wr_en   = 1'b1;
        clr_all = 1'b0;
        res_val = immx;
        case (op)
            OpLoad:    res_val = immx;
            OpAdd:     res_val = sum_ab;
            OpAddi:    res_val = sum_ai;
            OpSub:     res_val = dif_ab;
            OpSubi:    res_val = dif_ai;
            OpMul:     res_val = mul_lo;
            OpClear: begin
                clr_all = 1'b1;
                wr_en   = 1'b0;
                res_val = '0;
            end
            OpDisplay: begin
                wr_en   = 1'b0;
                res_val = regs_q[bus.addr1];
            end
            default:   res_val = immx;
        endcase
    end

    // enviar_q resets high so a button held through reset release is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            enviar_q <= 1'b1;
        end else begin
            enviar_q <= bus.enviar;
            done_q   <= commit;
            if (commit) begin
                result_q <= res_val;
                if (clr_all) begin
                    for (int i = 0; i < 16; i++) regs_q[i] <= '0;
                end else if (wr_en) begin
                    regs_q[bus.addr1] <= res_val;
                end
            end
        end
    end

`ifdef DATAPATH_OVF_EN
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W:0]     prod_hi;
    logic                ovf_d, ovf_q;

    assign prod    = $signed({{DATA_W{op_a[DATA_W-1]}}, op_a})
                   * $signed({{DATA_W{op_b[DATA_W-1]}}, op_b});
    assign mul_lo  = prod[DATA_W-1:0];
    assign prod_hi = prod[2*DATA_W-1:DATA_W-1];

    // Add overflows when like-signed operands give an unlike-signed sum; subtract when
    // the operands differ in sign and the result sign departs from A.
    always_comb begin
        ovf_d = 1'b0;
        case (op)
            OpAdd:  ovf_d = (op_a[DATA_W-1] == op_b[DATA_W-1])
                          && (sum_ab[DATA_W-1] != op_a[DATA_W-1]);
            OpAddi: ovf_d = (op_a[DATA_W-1] == immx[DATA_W-1])
                          && (sum_ai[DATA_W-1] != op_a[DATA_W-1]);
            OpSub:  ovf_d = (op_a[DATA_W-1] != op_b[DATA_W-1])
                          && (dif_ab[DATA_W-1] != op_a[DATA_W-1]);
            OpSubi: ovf_d = (op_a[DATA_W-1] != immx[DATA_W-1])
                          && (dif_ai[DATA_W-1] != op_a[DATA_W-1]);
            OpMul:  ovf_d = (prod_hi != '0) && (prod_hi != '1);
            default: ovf_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (commit) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign mul_lo  = op_a * op_b;
    assign bus.ovf = 1'b0;
`endif

    assign bus.v1     = op_a;
    assign bus.v2     = op_b;
    assign bus.result = result_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_mini_cpu_datapath.sv
// Directed bench for mini_cpu_datapath: an integer-arithmetic register-file model
// checked every cycle, plus hand-computed literal expectations.
module tb_mini_cpu_datapath;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [15:0] mdl [16];
    logic [15:0] exp_result = '0;
    logic        exp_done   = 1'b0;
    logic        exp_ovf    = 1'b0;

    mini_cpu_datapath_if #(.DATA_W(16), .IMM_W(7)) bus ();

    mini_cpu_datapath #(.DATA_W(16), .IMM_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] mkimm(input int v);
        logic [6:0] r;
        r[6]   = (v < 0);
        r[5:0] = 6'((v < 0) ? -v : v);
        return r;
    endfunction

    function automatic int imm_val(input logic [6:0] im);
        int mag = int'(im[5:0]);
        return im[6] ? -mag : mag;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        exp_result = '0;
        exp_done   = 1'b0;
        exp_ovf    = 1'b0;
    endtask

    // Applies one committed instruction to the model with plain signed integers.
    task automatic model_apply(input logic [2:0] op, input logic [3:0] a1, input logic [3:0] a2,
                               input logic [3:0] a3, input logic [6:0] im);
        int          sa, sb, ix, full;
        longint      p;
        logic [15:0] val;
        logic        o;
        sa = int'($signed(mdl[a2]));
        sb = int'($signed(mdl[a3]));
        ix = imm_val(im);
        o  = 1'b0;
        full = 0;
        p  = 0;
        case (op)
            3'd0: full = ix;
            3'd1: full = sa + sb;
            3'd2: full = sa + ix;
            3'd3: full = sa - sb;
            3'd4: full = sa - ix;
            3'd5: p = longint'(sa) * longint'(sb);
            default: full = 0;
        endcase
        if (op >= 3'd1 && op <= 3'd4) o = (full > 32767) || (full < -32768);
        if (op == 3'd5) o = (p > 64'sd32767) || (p < -64'sd32768);
        val = (op == 3'd5) ? p[15:0] : full[15:0];
        if (op == 3'd6) begin
            for (int i = 0; i < 16; i++) mdl[i] = '0;
            val = '0;
        end else if (op == 3'd7) begin
            val = mdl[a1];
        end else begin
            mdl[a1] = val;
        end
        exp_result = val;
`ifdef DATAPATH_OVF_EN
        exp_ovf = o;
`else
        exp_ovf = 1'b0;
`endif
    endtask

    // Present the instruction with enviar low, raise enviar, commit on the following edge.
    task automatic commit(input logic [2:0] op, input logic [3:0] a1, input logic [3:0] a2,
                          input logic [3:0] a3, input logic [6:0] im);
        @(posedge clk);
        #2;
        bus.opcode = op; bus.addr1 = a1; bus.addr2 = a2; bus.addr3 = a3; bus.imm = im;
        bus.enviar = 1'b0;
        @(posedge clk);
        #2 bus.enviar = 1'b1;
        @(posedge clk);
        #1;
        model_apply(op, a1, a2, a3, im);
        exp_done = 1'b1;
        @(posedge clk);
        #1 exp_done = 1'b0;
    endtask

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("result", bus.result, exp_result);
            check("done", {15'd0, bus.done}, {15'd0, exp_done});
            check("ovf", {15'd0, bus.ovf}, {15'd0, exp_ovf});
            check("v1", bus.v1, mdl[bus.addr2]);
            check("v2", bus.v2, mdl[bus.addr3]);
        end
    end

    initial begin
        int acc;
        model_reset();
        bus.opcode = '0; bus.addr1 = '0; bus.addr2 = '0; bus.addr3 = '0;
        bus.imm = '0; bus.enviar = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        check("rst_result", bus.result, 16'h0000);

        // LOAD R3 = 5
        commit(3'd0, 4'd3, 4'd3, 4'd0, 7'b0000101);
        #1 check("lit_load_r3", bus.v1, 16'd5);
        check("lit_load_res", bus.result, 16'd5);

        // LOAD R1=20, R2=-7, ADD and SUB into R4
        commit(3'd0, 4'd1, 4'd0, 4'd0, mkimm(20));
        commit(3'd0, 4'd2, 4'd0, 4'd0, 7'b1000111);
        commit(3'd1, 4'd4, 4'd1, 4'd2, 7'd0);
        #1 check("lit_add", bus.result, 16'd13);
        commit(3'd3, 4'd4, 4'd1, 4'd2, 7'd0);
        #1 check("lit_sub", bus.result, 16'h001B);

        // ADD with addr1 == addr2 reads old A: R4 = 27 + 27
        commit(3'd1, 4'd4, 4'd4, 4'd4, 7'd0);
        #1 check("lit_add_self", bus.result, 16'd54);

        // SUBI R5 = R1 - (-63), MUL R6 = R5*R5, negative-zero immediate
        commit(3'd4, 4'd5, 4'd1, 4'd0, 7'b1111111);
        #1 check("lit_subi", bus.result, 16'd83);
        commit(3'd5, 4'd6, 4'd5, 4'd5, 7'd0);
        #1 check("lit_mul", bus.result, 16'h1AE9);
        commit(3'd0, 4'd9, 4'd0, 4'd0, 7'b1000000);
        #1 check("lit_negzero", bus.result, 16'd0);

        // Signed MUL overflow: 6889 * 6889
        commit(3'd5, 4'd10, 4'd6, 4'd6, 7'd0);
        // Build R7 = 0x7FFF, then ADDI +1 wraps
        commit(3'd0, 4'd7, 4'd0, 4'd0, mkimm(63));
        acc = 63;
        while (acc + 63 <= 32767) begin
            commit(3'd2, 4'd7, 4'd7, 4'd0, mkimm(63));
            acc += 63;
        end
        commit(3'd2, 4'd7, 4'd7, 4'd0, mkimm(32767 - acc));
        #1 check("lit_7fff", bus.result, 16'h7FFF);
        commit(3'd2, 4'd7, 4'd7, 4'd0, mkimm(1));
        #1 check("lit_wrap", bus.result, 16'h8000);
`ifdef DATAPATH_OVF_EN
        check("lit_ovf_set", {15'd0, bus.ovf}, 16'd1);
`else
        check("lit_ovf_off", {15'd0, bus.ovf}, 16'd0);
`endif
        commit(3'd7, 4'd7, 4'd0, 4'd0, 7'd0);
        #1 check("lit_disp", bus.result, 16'h8000);
        check("lit_ovf_clr", {15'd0, bus.ovf}, 16'd0);

        // enviar held high after one commit: no further commits
        commit(3'd0, 4'd8, 4'd8, 4'd0, mkimm(-1));
        #1 bus.opcode = 3'd2;
        repeat (10) @(posedge clk);
        #1 check("lit_hold", bus.result, 16'hFFFF);

        // enviar high through reset release: no commit
        @(posedge clk);
        #3 rst = 1'b1;
        model_reset();
        #1 check("lit_arst_res", bus.result, 16'h0000);
        check("lit_arst_v1", bus.v1, 16'h0000);
        bus.opcode = 3'd0; bus.addr1 = 4'd2; bus.imm = mkimm(9); bus.enviar = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("lit_no_commit", bus.result, 16'h0000);

        // Fill all registers, then CLEAR
        for (int i = 0; i < 16; i++) commit(3'd0, 4'(i), 4'd0, 4'd0, mkimm(i + 1));
        commit(3'd6, 4'd0, 4'd0, 4'd0, 7'd0);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #2 bus.addr2 = 4'(i); bus.addr3 = 4'(15 - i);
            #1 check("lit_clr_v1", bus.v1, 16'h0000);
            check("lit_clr_v2", bus.v2, 16'h0000);
        end
        check("lit_clr_res", bus.result, 16'h0000);

        // Async reset mid-sequence after some state exists
        commit(3'd0, 4'd0, 4'd0, 4'd0, mkimm(-33));
        commit(3'd5, 4'd1, 4'd0, 4'd0, 7'd0);
        @(posedge clk);
        #4 rst = 1'b1;
        model_reset();
        #1 check("lit_arst2_res", bus.result, 16'h0000);
        check("lit_arst2_done", {15'd0, bus.done}, 16'd0);
        check("lit_arst2_ovf", {15'd0, bus.ovf}, 16'd0);
        check("lit_arst2_v1", bus.v1, 16'h0000);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
